// File: rtl/amo_rmw_sequencer_pkg.sv
// Shared types for the fused AMO read-modify-write sequencer.
//   amo_op_t        : AMO funct5 encodings understood by the ALU
//   amo_seq_state_t : sequencer FSM states
//   BE_NONE/BE_WORD : byte enables driven on load / store requests
package amo_rmw_sequencer_pkg;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_t;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        WB
    } amo_seq_state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/amo_rmw_sequencer_alu.sv
// Combinational AMO ALU: new_value = f(op, old_value, rs2).
//   op        : AMO funct5 encoding (unknown encodings behave as SWAP)
//   old_value : word read from memory
//   rs2       : register operand
//   new_value : word to be stored back
module amo_alu
    import amo_rmw_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] old_value,
    input  logic [DATA_W-1:0] rs2,
    output logic [DATA_W-1:0] new_value
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(old_value) < $signed(rs2);
    assign lt_unsigned = old_value < rs2;

    always_comb begin
        // NOTE: default assignment first so every path drives new_value and no latch is inferred.
        new_value = rs2;
        case (amo_op_t'(op))
            AMO_ADD:  new_value = old_value + rs2;
            AMO_SWAP: new_value = rs2;
            AMO_XOR:  new_value = old_value ^ rs2;
            AMO_OR:   new_value = old_value | rs2;
            AMO_AND:  new_value = old_value & rs2;
            AMO_MIN:  new_value = lt_signed   ? old_value : rs2;
            AMO_MAX:  new_value = lt_signed   ? rs2 : old_value;
            AMO_MINU: new_value = lt_unsigned ? old_value : rs2;
            AMO_MAXU: new_value = lt_unsigned ? rs2 : old_value;
            default:  new_value = rs2;
        endcase
    end

endmodule

// File: rtl/amo_rmw_sequencer.sv
// Fused AMO read-modify-write sequencer between the load/store queue and the
// load/store unit memory port. Loads the word, computes the new value, stores
// it, then returns the original word for writeback.
//   req_*  : AMO request from the load/store queue (accepted only in IDLE)
//   mem_*  : memory port, owned from request accept until the store is accepted
//   wb_*   : writeback of the original memory word, held until wb_ack
//   flush  : drops a request not yet issued to memory (IDLE / LD_REQ only)
//   busy   : sequencer is not IDLE
module amo_rmw_sequencer
    import amo_rmw_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_IDS = 8,
    parameter int ID_W    = $clog2(MAX_IDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_op,
    input  logic [DATA_W-1:0] req_rs2,
    input  logic [ID_W-1:0]   req_id,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ack,
    output logic [ID_W-1:0]   wb_id,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    amo_seq_state_t    state;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        op_q;
    logic [DATA_W-1:0] rs2_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] new_q;
    logic [DATA_W-1:0] alu_new;

    // The ALU works on the returning load data directly so the new value is
    // registered in the same cycle the old word is captured.
    amo_alu #(.DATA_W(DATA_W)) u_alu (
        .op        (op_q),
        .old_value (mem_rdata),
        .rs2       (rs2_q),
        .new_value (alu_new)
    );

    assign mem_addr  = addr_q;
    assign mem_wdata = new_q;
    assign wb_id     = id_q;
    assign wb_data   = old_q;

    // Outputs are registered alongside the state so they change only on the
    // transition into a state and stay stable while a request is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            rs2_q     <= '0;
            id_q      <= '0;
            old_q     <= '0;
            new_q     <= '0;
            mem_valid <= 1'b0;
            mem_load  <= 1'b0;
            mem_be    <= BE_NONE;
            wb_valid  <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        addr_q    <= req_addr;
                        op_q      <= req_op;
                        rs2_q     <= req_rs2;
                        id_q      <= req_id;
                        state     <= LD_REQ;
                        mem_valid <= 1'b1;
                        mem_load  <= 1'b1;
                        mem_be    <= BE_NONE;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LD_REQ: begin
                    // Flush takes priority: the load is abandoned even if the
                    // memory would have accepted it this cycle.
                    if (flush) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (mem_ready) begin
                        state     <= LD_WAIT;
                        mem_valid <= 1'b0;
                    end
                end
                LD_WAIT: begin
                    if (mem_rvalid) begin
                        old_q     <= mem_rdata;
                        new_q     <= alu_new;
                        state     <= ST_REQ;
                        mem_valid <= 1'b1;
                        mem_load  <= 1'b0;
                        mem_be    <= BE_WORD;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        state     <= WB;
                        mem_valid <= 1'b0;
                        wb_valid  <= 1'b1;
                    end
                end
                WB: begin
                    // req_ready rises only after this edge, so the earliest
                    // new accept is the cycle following wb_ack.
                    if (wb_ack) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                    wb_valid  <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
